// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decode/operand-issue stage feeding a 16-bit combinational ALU.
// Decodes R-type add/sub/mul and ADDI. It reads a register file that forwards the
// in-flight ALU result, and writes the ALU result back one cycle after issue.
// Handshake: a word is consumed on any rising edge where in_valid && in_ready.
// in_ready is purely !hold && !rst. It never depends on in_valid, and every
// consumed word (legal or illegal) is dropped from the producer side.
module alu_issue_stage #(
   parameter int NREG = 32,
   parameter int DW   = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [31:0]   in_instr,
   input  logic          hold,
   output logic [DW-1:0] ain,
   output logic [DW-1:0] bin,
   output logic [6:0]    alu_op,
   output logic          ex_valid,
   input  logic [DW-1:0] alu_result,
   input  logic          alu_z,
   output logic          zflag,
   output logic          illegal,
   input  logic [4:0]    dbg_addr,
   output logic [DW-1:0] dbg_data
);

   localparam logic [6:0] OPC_R    = 7'b0110011;
   localparam logic [6:0] OPC_I    = 7'b0010011;
   localparam logic [6:0] F7_ADD   = 7'b0000000;
   localparam logic [6:0] F7_SUB   = 7'b0100000;
   localparam logic [6:0] F7_MUL   = 7'b0000001;

   logic [DW-1:0] regs [NREG];
   logic [4:0]    ex_rd;

   logic [6:0]    f_funct7;
   logic [4:0]    f_rs2;
   logic [4:0]    f_rs1;
   logic [2:0]    f_funct3;
   logic [4:0]    f_rd;
   logic [6:0]    f_opcode;

   logic          is_r;
   logic          is_i;
   logic          legal;
   logic          accept;
   logic          wb_en;
   logic [DW-1:0] op_a;
   logic [DW-1:0] op_b;
   logic [DW-1:0] imm;
   logic [DW-1:0] next_bin;
   logic [6:0]    next_op;

   assign f_funct7 = in_instr[31:25];
   assign f_rs2    = in_instr[24:20];
   assign f_rs1    = in_instr[19:15];
   assign f_funct3 = in_instr[14:12];
   assign f_rd     = in_instr[11:7];
   assign f_opcode = in_instr[6:0];

   assign in_ready = !hold && !rst;
   assign accept   = in_valid && in_ready;
   // The in-flight instruction retires on any non-frozen, non-reset edge.
   assign wb_en    = ex_valid && !hold && !rst;

   // ADDI immediate: 12-bit signed field extended to the datapath width.
   assign imm = {{(DW-12){in_instr[31]}}, in_instr[31:20]};

   // Operand read: x0 is zero, then the live ALU result, then the register file.
   function automatic logic [DW-1:0] read_reg(input logic [4:0] idx);
      if (idx == 5'd0)
         return '0;
      else if (ex_valid && (ex_rd == idx))
         return alu_result;
      else
         return regs[idx];
   endfunction

   // Decode and operand selection for the word currently on in_instr.
   always_comb begin
      is_r     = 1'b0;
      is_i     = 1'b0;
      op_a     = '0;
      op_b     = '0;
      next_bin = '0;
      next_op  = F7_ADD;
      if (f_opcode == OPC_R && f_funct3 == 3'b000 &&
          (f_funct7 == F7_ADD || f_funct7 == F7_SUB || f_funct7 == F7_MUL))
         is_r = 1'b1;
      if (f_opcode == OPC_I && f_funct3 == 3'b000)
         is_i = 1'b1;
      op_a = read_reg(f_rs1);
      op_b = read_reg(f_rs2);
      if (is_r) begin
         next_bin = op_b;
         next_op  = f_funct7;
      end else begin
         next_bin = imm;
         next_op  = F7_ADD;
      end
   end

   assign legal = is_r || is_i;

   // Pipeline register driving the ALU. While hold is high it freezes, so the ALU output stays stable.
   always_ff @(posedge clk) begin
      if (rst) begin
         ain      <= '0;
         bin      <= '0;
         alu_op   <= F7_ADD;
         ex_rd    <= '0;
         ex_valid <= 1'b0;
         illegal  <= 1'b0;
      end else begin
         // accept already implies !hold, so a held cycle never pulses illegal.
         illegal <= accept && !legal;
         if (!hold) begin
            ex_valid <= accept && legal;
            if (accept && legal) begin
               ain    <= op_a;
               bin    <= next_bin;
               alu_op <= next_op;
               ex_rd  <= f_rd;
            end
         end
      end
   end

   // Writeback of the ALU result and its zero flag. A write to x0 is dropped, but it still updates zflag.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++)
            regs[i] <= '0;
         zflag <= 1'b0;
      end else if (wb_en) begin
         if (ex_rd != 5'd0)
            regs[ex_rd] <= alu_result;
         zflag <= alu_z;
      end
   end

   assign dbg_data = (dbg_addr == 5'd0) ? '0 : regs[dbg_addr];

endmodule
